mem_server: RTL and testbench
=============================

MEM_SERVER -- requirements
Module: mem_server

Interface
REQ-001 Parameter ADDR_BITS, default 8, address width; backing store depth 2**ADDR_BITS.
REQ-002 Parameter DATA_BITS, default 8, word width.
REQ-003 Parameter NUM_CHANNELS, default 4, number of independent request channels.
REQ-004 Parameter LATENCY, default 2, grant-to-ready cycles; legal range 1..15.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-007 mem_read_valid  input  NUM_CHANNELS  per-channel read request, held until ready.
REQ-008 mem_read_address  input  ADDR_BITS x NUM_CHANNELS  read address, stable while valid.
REQ-009 mem_read_ready  output  NUM_CHANNELS  one-cycle read-complete pulse.
REQ-010 mem_read_data  output  DATA_BITS x NUM_CHANNELS  read data, valid while ready is high.
REQ-011 mem_write_valid  input  NUM_CHANNELS  per-channel write request, held until ready.
REQ-012 mem_write_address / mem_write_data  input  ADDR_BITS / DATA_BITS x NUM_CHANNELS  write address and data.
REQ-013 mem_write_ready  output  NUM_CHANNELS  one-cycle write-complete pulse.
REQ-014 busy  output  1  high when any channel is not IDLE.

Function
REQ-015 Each channel SHALL run its own FSM: IDLE -> BUSY -> RESP -> DRAIN -> IDLE.
REQ-016 An IDLE channel SHALL be pending when either of its valids is high; a channel with both valids high SHALL be serviced as a write first.
REQ-017 A combinational round-robin arbiter SHALL grant at most one pending channel per cycle, searching upward from the channel after the last grant and wrapping from NUM_CHANNELS-1 to 0.
REQ-018 At the granting edge the channel SHALL latch op, address and write data, move to BUSY and load its countdown with LATENCY-1.
REQ-019 In BUSY the countdown SHALL decrement each edge; at the edge where it is 0, the channel SHALL perform the backing-store access and move to RESP.
REQ-020 The matching ready output SHALL be high for exactly the RESP cycle, so ready rises LATENCY cycles after the grant edge.
REQ-021 mem_read_data SHALL hold the word read at that access and SHALL keep its last value otherwise.
REQ-022 Backing-store accesses SHALL occur in grant order, at most one per cycle, so write-then-read ordering across channels follows grant order.
REQ-023 In DRAIN the channel SHALL return to IDLE at the first edge where the served op's valid is low; a request still held high SHALL NOT be re-served.
REQ-024 Out-of-range behaviour is excluded by construction: addresses are full-width, so there is no bounds check.

Reset
REQ-025 On reset low, every channel SHALL go IDLE, the arbiter pointer SHALL go to 0, the countdowns SHALL clear, and all ready, read_data and busy outputs SHALL go 0.
REQ-026 The backing store SHALL clear to all-zero on reset.
REQ-027 A reset mid-transaction SHALL abandon that transaction with no store update; a valid still high after reset deasserts SHALL be treated as a new request.

Configuration
REQ-028 With macro MEM_SERVER_PERF_EN defined, the block SHALL add 32-bit outputs perf_reads, perf_writes and perf_stalls.
REQ-029 perf_reads and perf_writes SHALL count completed accesses; perf_stalls SHALL count cycles in which pending exceeds granted.
REQ-030 All perf counters SHALL saturate, not wrap, and SHALL reset to 0.
REQ-031 Without MEM_SERVER_PERF_EN these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 Package mem_server_pkg SHALL hold the channel-state enum (IDLE/BUSY/RESP/DRAIN), the op enum (READ/WRITE) and the LATENCY bounds constants.
REQ-033 The arbiter SHALL be a separate sub-module, rr_arbiter, parameterised by requester count, with request, grant and advance ports.

Verification
REQ-034 Directed test: reset, then ch0 write addr 0x10 data 0xA5 held to ready. Required: ch0 write_ready pulses once, 2 cycles after grant; a subsequent ch1 read of 0x10 returns 0xA5.
REQ-035 Directed test: all 4 channels raise read valid in the same cycle. Required: grants go to ch0,1,2,3 on consecutive edges, with ready pulses on 4 consecutive cycles.
REQ-036 Directed test: ch2 raises read and write valid together, write addr 0x20 data 0x3C and read addr 0x20. Required: write completes first, then the read returns 0x3C.
REQ-037 Directed test: hold ch1 read valid high 3 cycles past ready. Required: exactly one ready pulse, and the channel leaves DRAIN only after valid drops.
REQ-038 Directed test: assert reset while ch0 write is in BUSY. Required: ready stays 0, the location reads 0x00 afterwards, and busy is 0 during reset.
REQ-039 Directed test, with MEM_SERVER_PERF_EN defined: run 3 writes, 5 reads and a 4-way collision. Required: perf_writes=3, perf_reads=5, perf_stalls matches the stall cycles observed in the collision.

Source files
------------

// File: rtl/mem_server_pkg.sv
// Shared types and constants for the multi-channel memory server.
// Channel FSM states, operation kinds, latency bounds and a saturating increment helper.
package mem_server_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } ch_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    // Wide enough to hold LATENCY_MAX-1.
    localparam int CNT_BITS    = 4;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_server_rr_arbiter.sv
// Combinational round-robin arbiter: one grant per cycle, searching upward
// from the requester after the last grant and wrapping to 0.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PTR_BITS = (N > 1) ? $clog2(N) : 1;

    logic [PTR_BITS-1:0] ptr_q, ptr_d;

    // Walk the offsets from highest to lowest so the nearest requester wins.
    always_comb begin
        int idx;
        grant = '0;
        ptr_d = ptr_q;
        idx   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                ptr_d      = PTR_BITS'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_server.sv
// Multi-channel memory server: per-channel request FSMs share one backing store
// through a round-robin arbiter. Define MEM_SERVER_PERF_EN to add perf counters.
module mem_server
    import mem_server_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]           mem_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]           mem_write_ready,
    output logic                            busy
`ifdef MEM_SERVER_PERF_EN
    ,
    output logic [31:0]                     perf_reads,
    output logic [31:0]                     perf_writes,
    output logic [31:0]                     perf_stalls
`endif
);

    localparam int NC    = NUM_CHANNELS;
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(LATENCY - 1);

    logic [NC-1:0]           pending;
    logic [NC-1:0]           grant;
    logic [NC-1:0]           access;
    logic [NC-1:0]           is_wr;
    logic [NC-1:0]           not_idle;
    logic [NC*ADDR_BITS-1:0] ch_addr;
    logic [NC*DATA_BITS-1:0] ch_wdata;

    logic [DATA_BITS-1:0]    mem_q [DEPTH];
    logic                    mem_we;
    logic [ADDR_BITS-1:0]    mem_waddr;
    logic [DATA_BITS-1:0]    mem_wdata;

    rr_arbiter #(.N(NC)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (pending),
        .advance (|pending),
        .grant   (grant)
    );

    for (genvar gi = 0; gi < NC; gi++) begin : g_ch
        ch_state_e            state_q, state_d;
        op_e                  op_q;
        logic [ADDR_BITS-1:0] addr_q;
        logic [DATA_BITS-1:0] wdata_q;
        logic [DATA_BITS-1:0] rdata_q;
        logic [CNT_BITS-1:0]  cnt_q;
        logic                 served_valid;
        logic                 rd_ready, wr_ready;

        assign served_valid = (op_q == OP_WRITE) ? mem_write_valid[gi] : mem_read_valid[gi];
        assign pending[gi]  = (state_q == ST_IDLE) && (mem_read_valid[gi] || mem_write_valid[gi]);
        assign access[gi]   = (state_q == ST_BUSY) && (cnt_q == '0);
        assign is_wr[gi]    = (op_q == OP_WRITE);
        assign not_idle[gi] = (state_q != ST_IDLE);
        assign ch_addr[gi*ADDR_BITS +: ADDR_BITS]  = addr_q;
        assign ch_wdata[gi*DATA_BITS +: DATA_BITS] = wdata_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // DRAIN waits for the served valid to drop so a held request is not re-served.
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE:  if (grant[gi])     state_d = ST_BUSY;
                ST_BUSY:  if (access[gi])    state_d = ST_RESP;
                ST_RESP:                     state_d = ST_DRAIN;
                ST_DRAIN: if (!served_valid) state_d = ST_IDLE;
                default:                     state_d = ST_IDLE;
            endcase
        end

        always_comb begin
            rd_ready = (state_q == ST_RESP) && (op_q == OP_READ);
            wr_ready = (state_q == ST_RESP) && (op_q == OP_WRITE);
        end

        // Write wins when both valids are high at the grant.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                op_q    <= OP_READ;
                addr_q  <= '0;
                wdata_q <= '0;
                cnt_q   <= '0;
                rdata_q <= '0;
            end else begin
                if (grant[gi]) begin
                    op_q    <= mem_write_valid[gi] ? OP_WRITE : OP_READ;
                    addr_q  <= mem_write_valid[gi] ? mem_write_address[gi*ADDR_BITS +: ADDR_BITS]
                                                   : mem_read_address[gi*ADDR_BITS +: ADDR_BITS];
                    wdata_q <= mem_write_data[gi*DATA_BITS +: DATA_BITS];
                    cnt_q   <= CNT_INIT;
                end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
                    cnt_q <= cnt_q - CNT_BITS'(1);
                end
                if (access[gi] && (op_q == OP_READ)) begin
                    rdata_q <= mem_q[addr_q];
                end
            end
        end

        assign mem_read_ready[gi]                       = rd_ready;
        assign mem_write_ready[gi]                      = wr_ready;
        assign mem_read_data[gi*DATA_BITS +: DATA_BITS] = rdata_q;
    end

    assign busy = |not_idle;

    // Grants are serialised with equal latency, so at most one channel accesses per cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        for (int i = 0; i < NC; i++) begin
            if (access[i] && is_wr[i]) begin
                mem_we    = 1'b1;
                mem_waddr = ch_addr[i*ADDR_BITS +: ADDR_BITS];
                mem_wdata = ch_wdata[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

`ifdef MEM_SERVER_PERF_EN
    logic [31:0] perf_reads_q, perf_writes_q, perf_stalls_q;
    logic        stall;

    // A stall is any cycle with more than one channel pending, since only one is granted.
    assign stall = (pending & (pending - NC'(1))) != '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_reads_q  <= '0;
            perf_writes_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (|(access & ~is_wr)) perf_reads_q  <= sat_inc(perf_reads_q);
            if (|(access & is_wr))  perf_writes_q <= sat_inc(perf_writes_q);
            if (stall)              perf_stalls_q <= sat_inc(perf_stalls_q);
        end
    end

    assign perf_reads  = perf_reads_q;
    assign perf_writes = perf_writes_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_mem_server.sv
// Directed bench for mem_server with hand-computed expectations; the
// MEM_SERVER_PERF_EN section only runs when the perf counters are built in.
module tb_mem_server;

    localparam int NC = 4;
    localparam int AB = 8;
    localparam int DB = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NC-1:0]    rvalid, wvalid;
    logic [NC*AB-1:0] raddr, waddr;
    logic [NC*DB-1:0] wdata;
    logic [NC-1:0]    rready, wready;
    logic [NC*DB-1:0] rdata;
    logic             busy;
`ifdef MEM_SERVER_PERF_EN
    logic [31:0]      perf_reads, perf_writes, perf_stalls;
`endif

    int total  = 0;
    int passed = 0;

    mem_server #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_valid    (rvalid),
        .mem_read_address  (raddr),
        .mem_read_ready    (rready),
        .mem_read_data     (rdata),
        .mem_write_valid   (wvalid),
        .mem_write_address (waddr),
        .mem_write_data    (wdata),
        .mem_write_ready   (wready),
        .busy              (busy)
`ifdef MEM_SERVER_PERF_EN
        ,
        .perf_reads        (perf_reads),
        .perf_writes       (perf_writes),
        .perf_stalls       (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on one channel: raise valid, wait for ready (bounded),
    // drop valid, then let the channel drain while counting any extra pulses.
    task automatic do_txn(input int ch, input bit wr, input logic [7:0] addr, input logic [7:0] data,
                          output int cyc, output logic [7:0] rdat, output int pulses);
        cyc    = -1;
        rdat   = 'x;
        pulses = 0;
        if (wr) begin
            waddr[ch*AB +: AB] = addr;
            wdata[ch*DB +: DB] = data;
            wvalid[ch]         = 1'b1;
        end else begin
            raddr[ch*AB +: AB] = addr;
            rvalid[ch]         = 1'b1;
        end
        for (int k = 1; k <= 20 && cyc < 0; k++) begin
            step();
            if (wr ? wready[ch] : rready[ch]) begin
                cyc  = k;
                rdat = rdata[ch*DB +: DB];
                pulses++;
            end
        end
        wvalid[ch] = 1'b0;
        rvalid[ch] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (wr ? wready[ch] : rready[ch]) pulses++;
        end
    endtask

    initial begin
        int         cyc, pl, wk, rk, b_hold, b_rel;
        logic [7:0] rd;
        int         fr[NC];
        int         np[NC];
        logic [7:0] got[NC];
        logic [7:0] exp35[NC];

        reset  = 1'b0;
        rvalid = '0;
        wvalid = '0;
        raddr  = '0;
        waddr  = '0;
        wdata  = '0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b1;
        step();

        // Write then read back across channels.
        do_txn(0, 1'b1, 8'h10, 8'hA5, cyc, rd, pl);
        chk("t34_wr_latency", cyc, 3);
        chk("t34_wr_pulses", pl, 1);
        chk("t34_idle_after", 32'(busy), 32'd0);
        do_txn(1, 1'b0, 8'h10, 8'h00, cyc, rd, pl);
        chk("t34_rd_latency", cyc, 3);
        chk("t34_rd_data", 32'(rd), 32'hA5);
        do_txn(3, 1'b1, 8'h13, 8'h77, cyc, rd, pl);
        chk("t35_pre_wr_latency", cyc, 3);

        // Four-way read collision; pointer is back at 0 after the ch3 grant.
        exp35 = '{8'hA5, 8'h00, 8'h00, 8'h77};
        raddr = 32'h1312_1110;
        for (int c = 0; c < NC; c++) begin
            fr[c] = -1;
            np[c] = 0;
            got[c] = 'x;
        end
        rvalid = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            step();
            for (int c = 0; c < NC; c++) begin
                if (rready[c]) begin
                    np[c]++;
                    if (fr[c] < 0) begin
                        fr[c]  = k;
                        got[c] = rdata[c*DB +: DB];
                    end
                    rvalid[c] = 1'b0;
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("t35_ready_cycle_ch%0d", c), fr[c], 3 + c);
            chk($sformatf("t35_pulses_ch%0d", c), np[c], 1);
            chk($sformatf("t35_data_ch%0d", c), 32'(got[c]), 32'(exp35[c]));
        end
        chk("t35_idle_after", 32'(busy), 32'd0);

        // Same channel, both valids: write served first, read re-arbitrated after drain.
        waddr[2*AB +: AB] = 8'h20;
        wdata[2*DB +: DB] = 8'h3C;
        raddr[2*AB +: AB] = 8'h20;
        wvalid[2] = 1'b1;
        rvalid[2] = 1'b1;
        wk = -1;
        rk = -1;
        rd = 'x;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (wready[2] && wk < 0) begin
                wk = k;
                wvalid[2] = 1'b0;
            end
            if (rready[2] && rk < 0) begin
                rk = k;
                rd = rdata[2*DB +: DB];
                rvalid[2] = 1'b0;
            end
        end
        chk("t36_wr_cycle", wk, 3);
        chk("t36_rd_cycle", rk, 8);
        chk("t36_rd_data", 32'(rd), 32'h3C);

        // Read valid held three cycles past ready.
        raddr[1*AB +: AB] = 8'h20;
        rvalid[1] = 1'b1;
        pl = 0;
        rk = -1;
        b_hold = -1;
        b_rel = -1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (rready[1]) begin
                pl++;
                if (rk < 0) begin
                    rk = k;
                    rd = rdata[1*DB +: DB];
                end
            end
            if (rk > 0 && k == rk + 4) b_rel = int'(busy);
            if (rk > 0 && k == rk + 3) begin
                b_hold = int'(busy);
                rvalid[1] = 1'b0;
            end
        end
        chk("t37_rd_cycle", rk, 3);
        chk("t37_pulses", pl, 1);
        chk("t37_rd_data", 32'(rd), 32'h3C);
        chk("t37_busy_while_held", b_hold, 1);
        chk("t37_busy_after_drop", b_rel, 0);

        // Reset while a write sits in BUSY.
        waddr[0 +: AB] = 8'h30;
        wdata[0 +: DB] = 8'h99;
        wvalid[0] = 1'b1;
        step();
        chk("t38_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("t38_busy_in_reset", 32'(busy), 32'd0);
        chk("t38_wready_in_reset", 32'(wready), 32'd0);
        chk("t38_rdata_in_reset", rdata, 32'd0);
        wvalid[0] = 1'b0;
        step();
        chk("t38_busy_in_reset_edge", 32'(busy), 32'd0);
        chk("t38_wready_in_reset_edge", 32'(wready), 32'd0);
        reset = 1'b1;
        step();
        do_txn(0, 1'b0, 8'h30, 8'h00, cyc, rd, pl);
        chk("t38_rd_latency", cyc, 3);
        chk("t38_abandoned_loc", 32'(rd), 32'h00);
        do_txn(2, 1'b0, 8'h10, 8'h00, cyc, rd, pl);
        chk("t38_store_cleared", 32'(rd), 32'h00);

`ifdef MEM_SERVER_PERF_EN
        reset = 1'b0;
        step();
        chk("t39_perf_rst", perf_reads | perf_writes | perf_stalls, 32'd0);
        reset = 1'b1;
        step();
        do_txn(0, 1'b1, 8'h40, 8'h11, cyc, rd, pl);
        do_txn(1, 1'b1, 8'h41, 8'h22, cyc, rd, pl);
        do_txn(2, 1'b1, 8'h42, 8'h33, cyc, rd, pl);
        do_txn(3, 1'b0, 8'h41, 8'h00, cyc, rd, pl);
        chk("t39_rd_data", 32'(rd), 32'h22);
        raddr  = 32'h4140_4142;
        rvalid = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            step();
            rvalid = rvalid & ~rready;
        end
        chk("t39_perf_writes", perf_writes, 32'd3);
        chk("t39_perf_reads", perf_reads, 32'd5);
        chk("t39_perf_stalls", perf_stalls, 32'd3);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
